msg_stream_arbiter: RTL

- Packet-level round-robin arbiter sharing one message-parser AXI-Stream slave port between NUM_SRC upstream AXI-Stream sources.
- Grant is locked for a whole packet, from first beat through the tlast handshake.
- Enforces a maximum packet length. Oversize packets are truncated with an error flag, and the remainder of the source's packet is drained.
- Sits directly in front of the message parser; the m_* side connects to the parser's s_* port.

---
 rtl/msg_stream_arbiter_if.sv | 29 ++
 rtl/msg_stream_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/msg_stream_arbiter_if.sv
// Stream bundle between the upstream sources, the arbiter and the message parser.
// The master modport is the arbiter's view; slave is the sources/parser side.
interface msg_stream_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_BYTES = 8
);
  logic [NUM_SRC-1:0]              s_tvalid;
  logic [NUM_SRC-1:0]              s_tready;
  logic [NUM_SRC-1:0]              s_tlast;
  logic [NUM_SRC-1:0]              s_tuser;
  logic [NUM_SRC*8*DATA_BYTES-1:0] s_tdata;
  logic [NUM_SRC*DATA_BYTES-1:0]   s_tkeep;
  logic                            m_tvalid;
  logic                            m_tready;
  logic                            m_tlast;
  logic                            m_tuser;
  logic [8*DATA_BYTES-1:0]         m_tdata;
  logic [DATA_BYTES-1:0]           m_tkeep;

  modport master (
    input  s_tvalid, s_tlast, s_tuser, s_tdata, s_tkeep, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep
  );

  modport slave (
    output s_tvalid, s_tlast, s_tuser, s_tdata, s_tkeep, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep
  );
endinterface

// File: rtl/msg_stream_arbiter.sv
// Packet-level round-robin arbiter in front of the message parser, with a
// per-packet beat limit: oversize packets are cut, flagged and the tail drained.
module msg_stream_arbiter #(
  parameter int  NUM_SRC       = 4,
  parameter int  DATA_BYTES    = 8,
  parameter int  MAX_PKT_BEATS = 4,
  localparam int ID_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int DATA_W        = 8 * DATA_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_enable,
  msg_stream_arbiter_if.master bus,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [15:0]          trunc_count
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  PASS  = 2'd1;
  localparam logic [1:0]  DRAIN = 2'd2;
  localparam logic [15:0] LIMIT = 16'(MAX_PKT_BEATS - 1);

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    next_ptr;
  logic [15:0]        beat_cnt;
  logic [NUM_SRC-1:0] req;
  logic               found;
  logic               cur_valid;
  logic               cur_last;
  logic               at_limit;
  logic               pass_hs;
  int                 idx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req         = bus.s_tvalid & src_enable;
  assign cur_valid   = bus.s_tvalid[grant_id];
  assign cur_last    = bus.s_tlast[grant_id];
  assign at_limit    = (beat_cnt == LIMIT);
  assign pass_hs     = (state == PASS) && cur_valid && bus.m_tready;
  assign next_ptr    = (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + 1'b1;
  assign grant_valid = (state != IDLE);

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  // Outputs are a pure mux of the granted source, so a stalled parser sees
  // the held source beat unchanged.
  always_comb begin
    bus.s_tready = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tuser  = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tkeep  = '0;
    if (state == PASS) begin
      bus.s_tready[grant_id] = bus.m_tready;
      bus.m_tvalid = cur_valid;
      bus.m_tdata  = bus.s_tdata[int'(grant_id)*DATA_W +: DATA_W];
      bus.m_tkeep  = bus.s_tkeep[int'(grant_id)*DATA_BYTES +: DATA_BYTES];
      bus.m_tlast  = cur_last | at_limit;
      bus.m_tuser  = (at_limit & ~cur_last) | bus.s_tuser[grant_id];
    end else if (state == DRAIN) begin
      bus.s_tready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      grant_id    <= '0;
      trunc_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= PASS;
          end
        end
        PASS: begin
          if (pass_hs) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (cur_last) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else if (at_limit) begin
              trunc_count <= sat_inc(trunc_count);
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cur_valid && cur_last) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
